// File: rtl/alu_req_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_req_scheduler_if
//  Description : Bundle of the two request channels, the response channel
//                and the ALU issue/return bus around alu_req_scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_req_scheduler_if #(
    parameter int WIDTH = 8
);
    // Requester 0 command channel
    logic                   req0_valid;
    logic                   req0_ready;
    logic [WIDTH-1:0]       req0_a;
    logic [WIDTH-1:0]       req0_b;
    logic [3:0]             req0_fun;

    // Requester 1 command channel
    logic                   req1_valid;
    logic                   req1_ready;
    logic [WIDTH-1:0]       req1_a;
    logic [WIDTH-1:0]       req1_b;
    logic [3:0]             req1_fun;

    // Response channel
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic                   rsp_id;
    logic [2*WIDTH-1:0]     rsp_data;
    logic                   rsp_err;

    // Shared ALU bus
    logic [WIDTH-1:0]       alu_a;
    logic [WIDTH-1:0]       alu_b;
    logic [3:0]             alu_fun;
    logic                   alu_en;
    logic [2*WIDTH-1:0]     alu_out;
    logic                   alu_valid;

    // Status
    logic                   busy;

    // Environment side: requesters, response consumer and the ALU itself
    modport master (
        output req0_valid, req0_a, req0_b, req0_fun,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_fun,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_err,
        output rsp_ready,
        input  alu_a, alu_b, alu_fun, alu_en,
        output alu_out, alu_valid,
        input  busy
    );

    // Scheduler side
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_fun,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_fun,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_err,
        input  rsp_ready,
        output alu_a, alu_b, alu_fun, alu_en,
        input  alu_out, alu_valid,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_req_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : alu_req_scheduler
//  Description : Round-robin scheduler placing one operation at a time from
//                two requesters onto a shared registered ALU, with
//                divide-by-zero rejection and a response timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_req_scheduler #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 4
) (
    input  logic                clk,
    input  logic                rst,
    alu_req_scheduler_if.slave  bus
);

    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]       FUN_DIV  = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                 state_q,      state_d;
    logic                   last_grant_q, last_grant_d;
    logic [CNT_W-1:0]       cnt_q,        cnt_d;
    logic [WIDTH-1:0]       alu_a_q,      alu_a_d;
    logic [WIDTH-1:0]       alu_b_q,      alu_b_d;
    logic [3:0]             alu_fun_q,    alu_fun_d;
    logic                   rsp_id_q,     rsp_id_d;
    logic [2*WIDTH-1:0]     rsp_data_q,   rsp_data_d;
    logic                   rsp_err_q,    rsp_err_d;

    logic                   w_grant;
    logic                   w_idle;
    logic                   w_accept;
    logic [WIDTH-1:0]       w_sel_a;
    logic [WIDTH-1:0]       w_sel_b;
    logic [3:0]             w_sel_fun;

    // Round-robin pick: a lone requester wins outright, a tie goes to the
    // side that was not granted last time.
    always_comb begin
        w_grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            w_grant = ~last_grant_q;
        end else if (bus.req1_valid) begin
            w_grant = 1'b1;
        end
    end

    assign w_idle         = (state_q == ST_IDLE);
    assign bus.req0_ready = w_idle && bus.req0_valid && !w_grant;
    assign bus.req1_ready = w_idle && bus.req1_valid &&  w_grant;
    assign w_accept       = bus.req0_ready || bus.req1_ready;

    assign w_sel_a   = w_grant ? bus.req1_a   : bus.req0_a;
    assign w_sel_b   = w_grant ? bus.req1_b   : bus.req0_b;
    assign w_sel_fun = w_grant ? bus.req1_fun : bus.req0_fun;

    // Next-state and datapath updates for the single in-flight operation.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_fun_d    = alu_fun_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    alu_a_d      = w_sel_a;
                    alu_b_d      = w_sel_b;
                    alu_fun_d    = w_sel_fun;
                    rsp_id_d     = w_grant;
                    last_grant_d = w_grant;
                    // Division by zero is answered directly; the ALU never sees it.
                    if ((w_sel_fun == FUN_DIV) && (w_sel_b == '0)) begin
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                        state_d    = ST_RESP;
                    end else begin
                        state_d    = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.alu_valid) begin
                    rsp_data_d = bus.alu_out;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_fun_q    <= '0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_fun_q    <= alu_fun_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // Strobes are decoded straight from the state register so they drop
    // together with it when reset is asserted.
    assign bus.alu_en    = (state_q == ST_ISSUE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.busy      = (state_q != ST_IDLE);

    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_fun   = alu_fun_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule
`default_nettype wire
